result_monitor: RTL and testbench

Synthesizable, parametrised self-checking monitor for the pipeline's observable result registers (v0, v1, and further channels). It replaces manual waveform inspection of the top-level simulation. It watches NCH result channels from MipsPipelineTop and detects each change event. Each event is compared in order against a loaded expected-vector sequence, and the block reports pass, fail, or timeout with diagnostic capture.

---
 rtl/result_monitor_pkg.sv | 20 ++
 rtl/result_expect_ram.sv | 27 ++
 rtl/result_monitor.sv | 162 ++++++++++++++++
 tb/tb_result_monitor.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_monitor_pkg.sv
// Shared types and constants for the result monitor and its expected-vector store.
package result_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_PASS = 3'd2,
    ST_FAIL = 3'd3,
    ST_TMO  = 3'd4
  } state_e;

  // cycle_count sticks here instead of wrapping
  localparam logic [31:0] CYC_SAT = 32'hFFFF_FFFF;

  // Index width of the expected-vector store
  function automatic int idxw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/result_expect_ram.sv
// Expected-vector store: one synchronous write port, one combinational read port, no reset.
module result_expect_ram
  import result_monitor_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = 64
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [idxw(DEPTH)-1:0]   waddr_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic [idxw(DEPTH)-1:0]   raddr_i,
  output logic [DW-1:0]            rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Write lands at the rising edge; contents survive reset
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/result_monitor.sv
// Self-checking monitor: detects change events on enabled result channels and
// compares them in order against the stored expected vectors.
module result_monitor
  import result_monitor_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NCH     = 2,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic [NCH*WIDTH-1:0]       obs,
  input  logic [NCH-1:0]             ch_en,
  input  logic                       start,
  input  logic                       exp_we,
  input  logic [$clog2(DEPTH)-1:0]   exp_addr,
  input  logic [NCH*WIDTH-1:0]       exp_data,
  input  logic [$clog2(DEPTH):0]     exp_count,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic                       timed_out,
  output logic [$clog2(DEPTH):0]     event_idx,
  output logic [NCH-1:0]             mismatch_mask,
  output logic [NCH*WIDTH-1:0]       fail_value,
  output logic [31:0]                cycle_count
);

  localparam int          IDXW      = idxw(DEPTH);
  localparam int          VW        = NCH * WIDTH;
  localparam logic [31:0] IDLE_LAST = 32'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [VW-1:0]   obs_q;
  logic [IDXW:0]   cnt_q, cnt_d;
  logic [IDXW:0]   idx_q, idx_d;
  logic [IDXW:0]   idx_inc;
  logic [31:0]     cyc_q, cyc_d;
  logic [31:0]     idle_q, idle_d;
  logic [NCH-1:0]  mmask_q, mmask_d;
  logic [VW-1:0]   fval_q, fval_d;

  logic [VW-1:0]   en_mask;
  logic [VW-1:0]   exp_rd;
  logic [NCH-1:0]  chan_mm;
  logic            change;
  logic            ram_we;

  // Writes are locked out while a check is running
  assign ram_we = exp_we && (state_q != ST_RUN);

  result_expect_ram #(
    .DEPTH (DEPTH),
    .DW    (VW)
  ) u_ram (
    .clk_i   (Clk),
    .we_i    (ram_we),
    .waddr_i (exp_addr),
    .wdata_i (exp_data),
    .raddr_i (idx_q[IDXW-1:0]),
    .rdata_o (exp_rd)
  );

  // Expand channel enables to bit masks and flag per-channel mismatches
  always_comb begin
    en_mask = '0;
    chan_mm = '0;
    for (int k = 0; k < NCH; k++) begin
      en_mask[k*WIDTH +: WIDTH] = {WIDTH{ch_en[k]}};
      chan_mm[k] = ch_en[k] && (obs[k*WIDTH +: WIDTH] != exp_rd[k*WIDTH +: WIDTH]);
    end
  end

  assign change  = |((obs ^ obs_q) & en_mask);
  assign idx_inc = idx_q + (IDXW+1)'(1);

  // Previous-cycle obs; tracked in every state so the baseline is the value seen with start
  always_ff @(posedge Clk) begin
    obs_q <= obs;
  end

  // State and bookkeeping registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      cyc_q   <= '0;
      idle_q  <= '0;
      mmask_q <= '0;
      fval_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      cyc_q   <= cyc_d;
      idle_q  <= idle_d;
      mmask_q <= mmask_d;
      fval_q  <= fval_d;
    end
  end

  // Next-state: arm on start, walk events in RUN, settle in a verdict state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    cyc_d   = cyc_q;
    idle_d  = idle_q;
    mmask_d = mmask_q;
    fval_d  = fval_q;

    // Cycle counter runs from arming until the next reset or re-arm
    if (state_q != ST_IDLE && cyc_q != CYC_SAT) begin
      cyc_d = cyc_q + 32'd1;
    end

    if (state_q == ST_RUN) begin
      if (cnt_q == '0) begin
        state_d = ST_PASS;
      end else if (change) begin
        // An event beats a timeout expiring in the same cycle
        idle_d = '0;
        if (chan_mm == '0) begin
          idx_d = idx_inc;
          if (idx_inc == cnt_q) begin
            state_d = ST_PASS;
          end
        end else begin
          state_d = ST_FAIL;
          mmask_d = chan_mm;
          fval_d  = obs;
        end
      end else if (idle_q == IDLE_LAST) begin
        state_d = ST_TMO;
      end else begin
        idle_d = idle_q + 32'd1;
      end
    end else if (start) begin
      state_d = ST_RUN;
      cnt_d   = exp_count;
      idx_d   = '0;
      cyc_d   = '0;
      idle_d  = '0;
      mmask_d = '0;
      fval_d  = '0;
    end
  end

  assign busy          = (state_q == ST_RUN);
  assign pass          = (state_q == ST_PASS);
  assign fail          = (state_q == ST_FAIL);
  assign timed_out     = (state_q == ST_TMO);
  assign done          = pass | fail | timed_out;
  assign event_idx     = idx_q;
  assign mismatch_mask = mmask_q;
  assign fail_value    = fval_q;
  assign cycle_count   = cyc_q;

endmodule

// File: tb/tb_result_monitor.sv
// Directed and randomized checks of result_monitor against an event-list reference model.
module tb_result_monitor;

  localparam int WIDTH   = 32;
  localparam int NCH     = 2;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 16;
  localparam int VW      = NCH * WIDTH;
  localparam int MAXL    = 160;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic [VW-1:0] obs = '0;
  logic [1:0]    ch_en = 2'b11;
  logic          start = 1'b0;
  logic          exp_we = 1'b0;
  logic [3:0]    exp_addr = '0;
  logic [VW-1:0] exp_data = '0;
  logic [4:0]    exp_count = '0;
  logic          busy, done, pass, fail, timed_out;
  logic [4:0]    event_idx;
  logic [1:0]    mismatch_mask;
  logic [VW-1:0] fail_value;
  logic [31:0]   cycle_count;

  int tests = 0;
  int fails = 0;

  logic [VW-1:0] mem_m [DEPTH];
  logic [VW-1:0] oseq  [MAXL+1];

  result_monitor #(
    .WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk(Clk), .Rst(Rst), .obs(obs), .ch_en(ch_en), .start(start),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data), .exp_count(exp_count),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .timed_out(timed_out),
    .event_idx(event_idx), .mismatch_mask(mismatch_mask), .fail_value(fail_value),
    .cycle_count(cycle_count)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, want);
    end
  endtask

  task automatic wr(input int a, input logic [VW-1:0] d);
    exp_we   = 1'b1;
    exp_addr = 4'(a);
    exp_data = d;
    tick();
    exp_we   = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_pass"}, 64'(pass), 64'd0);
    chk({tag, "_fail"}, 64'(fail), 64'd0);
    chk({tag, "_tmo"},  64'(timed_out), 64'd0);
    chk({tag, "_idx"},  64'(event_idx), 64'd0);
    chk({tag, "_mask"}, 64'(mismatch_mask), 64'd0);
    chk({tag, "_fval"}, fail_value, 64'd0);
    chk({tag, "_cyc"},  64'(cycle_count), 64'd0);
  endtask

  // Walk the per-cycle obs list: pick out change events, match them in order
  // against mem_m, and find which verdict arrives first and in which cycle.
  // vk: 1 pass, 2 fail, 3 timeout. vj: cycle offset (from start) where done first reads 1.
  function automatic void model(input int cnt, input logic [1:0] en, input int n,
                                output int vj, output int vk, output int vidx,
                                output logic [1:0] vmask, output logic [VW-1:0] vfval);
    int prev;
    int idx;
    logic [VW-1:0] cur, pv, m;
    logic [1:0] mm;
    prev = 0; idx = 0;
    m = {{32{en[1]}}, {32{en[0]}}};
    vj = -1; vk = 0; vidx = 0; vmask = '0; vfval = '0;
    if (cnt == 0) begin
      vj = 2; vk = 1;
      return;
    end
    for (int j = 1; j <= n + TIMEOUT + 2; j++) begin
      if (j == prev + TIMEOUT + 1) begin
        vj = j; vk = 3; vidx = idx;
        return;
      end
      cur = oseq[(j <= n) ? j : n];
      pv  = oseq[((j - 1) <= n) ? (j - 1) : n];
      if (((cur ^ pv) & m) != '0) begin
        prev = j;
        for (int c = 0; c < 2; c++)
          mm[c] = en[c] && (cur[c*32 +: 32] != mem_m[idx][c*32 +: 32]);
        if (mm != 2'b00) begin
          vj = j + 1; vk = 2; vidx = idx; vmask = mm; vfval = cur;
          return;
        end
        idx++;
        if (idx == cnt) begin
          vj = j + 1; vk = 1; vidx = idx;
          return;
        end
      end
    end
  endfunction

  initial begin
    int cnt, n, gap, r, gj, vj, vk, vidx;
    logic [1:0] en, vmask, s_mask;
    logic [VW-1:0] vfval, s_fval, nv;
    logic s_pass, s_fail, s_tmo;
    logic [4:0] s_idx;

    // Reset state
    tick(); tick(); tick();
    chk_all_zero("reset");
    Rst = 1'b0;
    tick();

    // Directed: two matching events then pass
    wr(0, 64'h0000_0000_0000_0005);
    wr(1, 64'h0000_0007_0000_0005);
    obs = '0; ch_en = 2'b11; exp_count = 5'd2;
    start = 1'b1; tick(); start = 1'b0;
    chk("d1_busy", 64'(busy), 64'd1);
    chk("d1_cyc0", 64'(cycle_count), 64'd0);
    tick();
    chk("d1_cyc1", 64'(cycle_count), 64'd1);
    obs[31:0] = 32'd5; tick();
    chk("d1_idx1", 64'(event_idx), 64'd1);
    tick();
    obs[63:32] = 32'd7;
    chk("d1_nopass_yet", 64'(pass), 64'd0);
    tick();
    chk("d1_pass", 64'(pass), 64'd1);
    chk("d1_done", 64'(done), 64'd1);
    chk("d1_idx2", 64'(event_idx), 64'd2);
    chk("d1_busy_off", 64'(busy), 64'd0);

    // Directed: wrong v1 value fails
    obs = '0;
    start = 1'b1; tick(); start = 1'b0;
    obs[31:0] = 32'd5; tick();
    chk("d2_idx1", 64'(event_idx), 64'd1);
    obs[63:32] = 32'd9; tick();
    chk("d2_fail", 64'(fail), 64'd1);
    chk("d2_pass", 64'(pass), 64'd0);
    chk("d2_idx", 64'(event_idx), 64'd1);
    chk("d2_mask", 64'(mismatch_mask), 64'd2);
    chk("d2_fval", fail_value, 64'h0000_0009_0000_0005);

    // Directed: timeout exactly TIMEOUT+1 cycles after start
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    chk("d3_tmo_early", 64'(timed_out), 64'd0);
    chk("d3_busy", 64'(busy), 64'd1);
    tick();
    chk("d3_tmo", 64'(timed_out), 64'd1);
    chk("d3_pass", 64'(pass), 64'd0);
    chk("d3_fail", 64'(fail), 64'd0);

    // Directed: disabled channel toggles are not events
    obs = '0; ch_en = 2'b01;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      obs[63:32] = obs[63:32] + 32'd1;
      tick();
    end
    chk("d4_noevt", 64'(event_idx), 64'd0);
    obs[31:0] = 32'd5; tick();
    chk("d4_idx1", 64'(event_idx), 64'd1);

    // Directed: reset mid-run clears outputs, memory survives
    Rst = 1'b1; tick(); Rst = 1'b0;
    chk_all_zero("d5_rst");
    ch_en = 2'b11; obs = '0;
    start = 1'b1; tick(); start = 1'b0;
    obs[31:0] = 32'd5; tick();
    chk("d5_idx1", 64'(event_idx), 64'd1);
    obs[63:32] = 32'd7; tick();
    chk("d5_pass", 64'(pass), 64'd1);
    chk("d5_idx2", 64'(event_idx), 64'd2);

    // Directed: zero-length sequence, write attempt while running
    exp_count = 5'd0;
    start = 1'b1; tick(); start = 1'b0;
    chk("d6_busy", 64'(busy), 64'd1);
    chk("d6_pass_early", 64'(pass), 64'd0);
    exp_we = 1'b1; exp_addr = 4'd0; exp_data = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    exp_we = 1'b0;
    chk("d6_pass", 64'(pass), 64'd1);
    obs = '0; exp_count = 5'd1;
    start = 1'b1; tick(); start = 1'b0;
    obs[31:0] = 32'd5; tick();
    chk("d6_ram_kept", 64'(pass), 64'd1);
    chk("d6_ram_nofail", 64'(fail), 64'd0);

    // Randomized scenarios against the event-list model
    for (int it = 0; it < 24; it++) begin
      cnt = $urandom_range(1, 5);
      en  = 2'($urandom_range(1, 3));
      ch_en = en;
      for (int k = 0; k < cnt; k++)
        wr(k, {32'($urandom_range(0, 3)), 32'($urandom_range(0, 3))});
      n = 0;
      oseq[0] = {32'($urandom_range(0, 3)), 32'($urandom_range(0, 3))};
      for (int k = 0; k <= cnt; k++) begin
        r = $urandom_range(0, 11);
        gap = (r == 0) ? TIMEOUT - 1 : (r == 1) ? TIMEOUT : (r == 2) ? TIMEOUT + 1
              : $urandom_range(1, 3);
        for (int g = 1; g < gap; g++) begin
          n++;
          oseq[n] = oseq[n-1];
          for (int c = 0; c < 2; c++)
            if (!en[c] && $urandom_range(0, 1) == 1) oseq[n][c*32 +: 32] = 32'($urandom);
        end
        n++;
        if (k < cnt && $urandom_range(0, 4) != 0) nv = mem_m[k];
        else nv = {32'($urandom_range(0, 3)), 32'($urandom_range(0, 3))};
        oseq[n] = nv;
      end
      model(cnt, en, n, vj, vk, vidx, vmask, vfval);

      exp_count = 5'(cnt);
      obs = oseq[0];
      start = 1'b1; tick(); start = 1'b0;
      gj = -1;
      s_pass = 0; s_fail = 0; s_tmo = 0; s_idx = '0; s_mask = '0; s_fval = '0;
      for (int j = 1; j <= n + TIMEOUT + 4; j++) begin
        if (gj < 0 && done) begin
          gj = j; s_pass = pass; s_fail = fail; s_tmo = timed_out;
          s_idx = event_idx; s_mask = mismatch_mask; s_fval = fail_value;
        end
        obs = oseq[(j <= n) ? j : n];
        tick();
      end
      chk($sformatf("rnd%0d_cycle", it), 64'(gj), 64'(vj));
      chk($sformatf("rnd%0d_pass", it), 64'(s_pass), 64'(vk == 1));
      chk($sformatf("rnd%0d_fail", it), 64'(s_fail), 64'(vk == 2));
      chk($sformatf("rnd%0d_tmo", it), 64'(s_tmo), 64'(vk == 3));
      chk($sformatf("rnd%0d_idx", it), 64'(s_idx), 64'(vidx));
      chk($sformatf("rnd%0d_mask", it), 64'(s_mask), 64'(vmask));
      chk($sformatf("rnd%0d_fval", it), s_fval, vfval);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
